pcpi_muldiv: RTL and testbench

- PCPI responder implementing RV32M (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the torv32 pipeline.
- Sits on the core's pcpi_* bus. The core holds pcpi_valid/insn/rs1/rs2 stable while stalled and captures pcpi_rd in the same cycle pcpi_ready is high.
- Single-cycle-issue multiplier plus an iterative radix-2^DIV_BITS divider in a sub-module.

---
 rtl/pcpi_muldiv_pkg.sv | 23 ++
 rtl/pcpi_div_unit.sv | 95 +++++++++
 rtl/pcpi_muldiv.sv | 143 ++++++++++++++
 tb/tb_pcpi_muldiv.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcpi_muldiv_pkg.sv
// Shared constants and state encoding for the RV32M PCPI responder.
package pcpi_muldiv_pkg;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/pcpi_div_unit.sv
// Iterative restoring divider, DIV_BITS quotient bits per cycle, with sign fixup.
// A start while busy simply reloads, which is how an aborted divide is discarded.
module pcpi_div_unit
    import pcpi_muldiv_pkg::*;
#(
    parameter int DIV_BITS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int STEPS = 32 / DIV_BITS;
    localparam int CW    = $clog2(STEPS + 1);

    logic [31:0]   quo_q, rem_q, dsr_q;
    logic [31:0]   quo_d, rem_d;
    logic [CW-1:0] cnt_q;
    logic          busy_q, done_q, quo_neg_q, rem_neg_q;

    logic          a_neg, b_neg;
    logic [31:0]   a_mag, b_mag;

    assign a_neg = signed_op & dividend[31];
    assign b_neg = signed_op & divisor[31];
    assign a_mag = a_neg ? (~dividend + 32'd1) : dividend;
    assign b_mag = b_neg ? (~divisor + 32'd1) : divisor;

    // DIV_BITS restoring steps on the magnitude registers
    always_comb begin
        logic [31:0] r;
        logic [31:0] q;
        logic [32:0] t;
        r = rem_q;
        q = quo_q;
        t = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            t = {r, q[31]};
            q = {q[30:0], 1'b0};
            if (t >= {1'b0, dsr_q}) begin
                t    = t - {1'b0, dsr_q};
                q[0] = 1'b1;
            end
            r = t[31:0];
        end
        rem_d = r;
        quo_d = q;
    end

    // Operand load on start, then one iteration per cycle until the count runs out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (start) begin
            quo_q     <= a_mag;
            rem_q     <= '0;
            dsr_q     <= b_mag;
            cnt_q     <= CW'(STEPS);
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            quo_neg_q <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
        end else if (busy_q) begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_neg_q ? (~quo_q + 32'd1) : quo_q;
    assign remainder = rem_neg_q ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/pcpi_muldiv.sv
// RV32M PCPI responder: decode, single-issue multiplier, divide special cases, handshake FSM.
module pcpi_muldiv
    import pcpi_muldiv_pkg::*;
#(
    parameter int ENABLE_DIV = 1,
    parameter int DIV_BITS   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);

    state_e      state_q, state_d;
    logic [2:0]  funct3_q;
    logic [31:0] rs1_q, rs2_q, result_q;

    logic        is_muldiv, is_mul, is_div, accept;
    logic [2:0]  insn_f3;
    logic        unused_bits;

    assign insn_f3   = pcpi_insn[14:12];
    assign is_muldiv = (pcpi_insn[6:0] == OP_REG) && (pcpi_insn[31:25] == F7_MULDIV);
    assign is_mul    = is_muldiv && !insn_f3[2];
    assign is_div    = is_muldiv && insn_f3[2] && (ENABLE_DIV != 0);
    assign accept    = pcpi_valid && (state_q == ST_IDLE) && (is_mul || is_div);

    // Multiplier: 33x33 product with per-op sign extension, evaluated on latched operands
    logic        mul_signed_a, mul_signed_b;
    logic [32:0] a_ext, b_ext;
    logic [65:0] a_wide, b_wide, product;
    logic [31:0] mul_result;

    assign mul_signed_a = (funct3_q == F3_MUL) || (funct3_q == F3_MULH) || (funct3_q == F3_MULHSU);
    assign mul_signed_b = (funct3_q == F3_MUL) || (funct3_q == F3_MULH);
    assign a_ext        = {mul_signed_a & rs1_q[31], rs1_q};
    assign b_ext        = {mul_signed_b & rs2_q[31], rs2_q};
    assign a_wide       = {{33{a_ext[32]}}, a_ext};
    assign b_wide       = {{33{b_ext[32]}}, b_ext};
    assign product      = a_wide * b_wide;
    assign mul_result   = (funct3_q == F3_MUL) ? product[31:0] : product[63:32];

    // Divider: started straight from the bus in the accept cycle so it runs alongside the latch
    logic        div_busy, div_done;
    logic [31:0] div_quo, div_rem, div_result;
    logic        div_is_rem, div_is_signed;

    generate
        if (ENABLE_DIV != 0) begin : g_div
            pcpi_div_unit #(.DIV_BITS(DIV_BITS)) u_div (
                .clk       (clk),
                .reset     (reset),
                .start     (accept && is_div),
                .signed_op ((insn_f3 == F3_DIV) || (insn_f3 == F3_REM)),
                .dividend  (pcpi_rs1),
                .divisor   (pcpi_rs2),
                .busy      (div_busy),
                .done      (div_done),
                .quotient  (div_quo),
                .remainder (div_rem)
            );
        end else begin : g_no_div
            assign div_busy = 1'b0;
            assign div_done = 1'b0;
            assign div_quo  = '0;
            assign div_rem  = '0;
        end
    endgenerate

    assign div_is_rem    = (funct3_q == F3_REM) || (funct3_q == F3_REMU);
    assign div_is_signed = (funct3_q == F3_DIV) || (funct3_q == F3_REM);

    // Special cases override whatever the iterative engine produced
    always_comb begin
        div_result = div_is_rem ? div_rem : div_quo;
        if (rs2_q == 32'd0) begin
            div_result = div_is_rem ? rs1_q : 32'hFFFF_FFFF;
        end else if (div_is_signed && rs1_q == 32'h8000_0000 && rs2_q == 32'hFFFF_FFFF) begin
            div_result = div_is_rem ? 32'd0 : 32'h8000_0000;
        end
    end

    assign unused_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7], product[65:64]};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state; a dropped pcpi_valid aborts any operation in flight
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = is_div ? ST_DIV : ST_MUL;
            ST_MUL:  state_d = pcpi_valid ? ST_DONE : ST_IDLE;
            ST_DIV: begin
                if (!pcpi_valid)                state_d = ST_IDLE;
                else if (div_done)              state_d = ST_DONE;
                else if (!div_busy)             state_d = ST_IDLE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs; wait is gated by reset so everything reads 0 the moment reset rises
    always_comb begin
        pcpi_ready = (state_q == ST_DONE);
        pcpi_wr    = (state_q == ST_DONE);
        pcpi_rd    = result_q;
        pcpi_wait  = !reset && pcpi_valid &&
                     (((state_q == ST_IDLE) && (is_mul || is_div)) ||
                      (state_q == ST_MUL) || (state_q == ST_DIV));
    end

    // Operand latch on accept and result capture one cycle before DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            funct3_q <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                funct3_q <= insn_f3;
                rs1_q    <= pcpi_rs1;
                rs2_q    <= pcpi_rs2;
            end
            if (state_q == ST_MUL && pcpi_valid)
                result_q <= mul_result;
            if (state_q == ST_DIV && pcpi_valid && div_done)
                result_q <= div_result;
        end
    end

endmodule

// File: tb/tb_pcpi_muldiv.sv
// Directed bench for pcpi_muldiv with default parameters (ENABLE_DIV=1, DIV_BITS=1).
module tb_pcpi_muldiv;
    import pcpi_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_rd;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pcpi_muldiv dut (
        .clk        (clk),
        .reset      (reset),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready)
    );

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // Presents one instruction at a negedge and holds it until ready; reports
    // cycles to ready (cycle 0 = presentation cycle), rd, and handshake health.
    task automatic issue(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] rd,
                         output bit wait_ok, output bit wr_ok);
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = insn;
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        #1;
        lat = -1; rd = 'x; wait_ok = 1'b1; wr_ok = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (pcpi_wr !== pcpi_ready) wr_ok = 1'b0;
            if (pcpi_ready === 1'b1) begin
                lat = c;
                rd  = pcpi_rd;
                break;
            end
            if (pcpi_wait !== 1'b1) wait_ok = 1'b0;
            @(negedge clk); #1;
        end
        pcpi_valid = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        vectors++; if (pcpi_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0", pcpi_ready); end
        vectors++; if (pcpi_wr !== 1'b0) begin miscompares++; $display("FAIL reset_wr: got %b expected 0", pcpi_wr); end
        vectors++; if (pcpi_wait !== 1'b0) begin miscompares++; $display("FAIL reset_wait: got %b expected 0", pcpi_wait); end
        vectors++; if (pcpi_rd !== 32'd0) begin miscompares++; $display("FAIL reset_rd: got %h expected 00000000", pcpi_rd); end
        $display("reset: outputs checked");
    endtask

    // Shared by multiply and divide tables: latency, result, wait and wr behaviour.
    task automatic test_ops(input string tag, input logic [31:0] ins[4], input logic [31:0] a[4],
                            input logic [31:0] b[4], input logic [31:0] exp[4], input int exp_lat);
        int lat; logic [31:0] rd; bit wok, wrok;
        for (int i = 0; i < 4; i++) begin
            issue(ins[i], a[i], b[i], lat, rd, wok, wrok);
            $display("%s[%0d]: insn=%h rs1=%h rs2=%h rd=%h lat=%0d", tag, i, ins[i], a[i], b[i], rd, lat);
            vectors++; if (lat !== exp_lat) begin miscompares++; $display("FAIL %s[%0d]_latency: got %0d expected %0d", tag, i, lat, exp_lat); end
            vectors++; if (rd !== exp[i]) begin miscompares++; $display("FAIL %s[%0d]_rd: got %h expected %h", tag, i, rd, exp[i]); end
            vectors++; if (wok !== 1'b1) begin miscompares++; $display("FAIL %s[%0d]_wait: got dropout expected wait high until ready", tag, i); end
            vectors++; if (wrok !== 1'b1) begin miscompares++; $display("FAIL %s[%0d]_wr: got wr!=ready expected wr==ready", tag, i); end
        end
    endtask

    task automatic test_mul();
        logic [31:0] ins[4], a[4], b[4], exp[4];
        ins = '{mk(F7_MULDIV, F3_MULH), mk(F7_MULDIV, F3_MUL), mk(F7_MULDIV, F3_MULHU), mk(F7_MULDIV, F3_MULHSU)};
        a   = '{32'h8000_0000, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF};
        b   = '{32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        exp = '{32'h4000_0000, 32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        test_ops("mul", ins, a, b, exp, 2);
    endtask

    task automatic test_div();
        logic [31:0] ins[4], a[4], b[4], exp[4];
        ins = '{mk(F7_MULDIV, F3_DIV), mk(F7_MULDIV, F3_REM), mk(F7_MULDIV, F3_DIVU), mk(F7_MULDIV, F3_REMU)};
        a   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        b   = '{32'd2,         32'd2,         32'd7,   32'd7};
        exp = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14,  32'd2};
        test_ops("div", ins, a, b, exp, 34);
    endtask

    task automatic test_div_special();
        logic [31:0] ins[4], a[4], b[4], exp[4];
        ins = '{mk(F7_MULDIV, F3_DIVU), mk(F7_MULDIV, F3_REM), mk(F7_MULDIV, F3_DIV), mk(F7_MULDIV, F3_REM)};
        a   = '{32'd5,         32'd5, 32'h8000_0000, 32'h8000_0000};
        b   = '{32'd0,         32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        exp = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        test_ops("divspec", ins, a, b, exp, 34);
    endtask

    task automatic test_back_to_back();
        int pulses[4]; logic [31:0] rds[4]; int n; bit wrok;
        n = 0; wrok = 1'b1;
        @(negedge clk);
        pcpi_valid = 1'b1; pcpi_insn = mk(F7_MULDIV, F3_MUL); pcpi_rs1 = 32'd7; pcpi_rs2 = 32'hFFFF_FFFD;
        #1;
        for (int c = 0; c < 60; c++) begin
            if (c == 3) begin
                pcpi_insn = mk(F7_MULDIV, F3_DIV); pcpi_rs1 = 32'hFFFF_FFF9; pcpi_rs2 = 32'd2;
                #1;
            end
            if (pcpi_wr !== pcpi_ready) wrok = 1'b0;
            if (pcpi_ready === 1'b1 && n < 4) begin
                pulses[n] = c; rds[n] = pcpi_rd; n++;
                if (n == 2) pcpi_valid = 1'b0;
            end
            @(negedge clk); #1;
        end
        pcpi_valid = 1'b0;
        $display("b2b: %0d ready pulses", n);
        vectors++; if (n !== 2) begin miscompares++; $display("FAIL b2b_pulses: got %0d expected 2", n); end
        if (n >= 1) begin
            vectors++; if (pulses[0] !== 2) begin miscompares++; $display("FAIL b2b_first_cycle: got %0d expected 2", pulses[0]); end
            vectors++; if (rds[0] !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL b2b_first_rd: got %h expected ffffffeb", rds[0]); end
        end
        if (n >= 2) begin
            vectors++; if (pulses[1] !== 37) begin miscompares++; $display("FAIL b2b_second_cycle: got %0d expected 37", pulses[1]); end
            vectors++; if (rds[1] !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL b2b_second_rd: got %h expected fffffffd", rds[1]); end
        end
        vectors++; if (wrok !== 1'b1) begin miscompares++; $display("FAIL b2b_wr: got wr!=ready expected wr==ready"); end
    endtask

    task automatic test_abort();
        bit saw_ready; int lat; logic [31:0] rd; bit wok, wrok;
        saw_ready = 1'b0;
        @(negedge clk);
        pcpi_valid = 1'b1; pcpi_insn = mk(F7_MULDIV, F3_DIVU); pcpi_rs1 = 32'd100; pcpi_rs2 = 32'd7;
        #1;
        repeat (5) begin @(negedge clk); #1; end
        pcpi_valid = 1'b0;
        #1;
        vectors++; if (pcpi_wait !== 1'b0) begin miscompares++; $display("FAIL abort_wait: got %b expected 0", pcpi_wait); end
        for (int c = 0; c < 50; c++) begin
            if (pcpi_ready !== 1'b0 || pcpi_wr !== 1'b0) saw_ready = 1'b1;
            @(negedge clk); #1;
        end
        $display("abort: divide dropped at cycle 5");
        vectors++; if (saw_ready !== 1'b0) begin miscompares++; $display("FAIL abort_no_ready: got pulse expected none"); end
        issue(mk(F7_MULDIV, F3_MUL), 32'd6, 32'd9, lat, rd, wok, wrok);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL abort_then_mul_latency: got %0d expected 2", lat); end
        vectors++; if (rd !== 32'd54) begin miscompares++; $display("FAIL abort_then_mul_rd: got %h expected 00000036", rd); end
    endtask

    task automatic test_nomatch();
        bit saw_wait, saw_ready;
        saw_wait = 1'b0; saw_ready = 1'b0;
        @(negedge clk);
        pcpi_valid = 1'b1; pcpi_insn = mk(7'b0000000, 3'b000); pcpi_rs1 = 32'd3; pcpi_rs2 = 32'd4;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (pcpi_wait !== 1'b0) saw_wait = 1'b1;
            if (pcpi_ready !== 1'b0 || pcpi_wr !== 1'b0) saw_ready = 1'b1;
            @(negedge clk); #1;
        end
        pcpi_valid = 1'b0;
        $display("nomatch: ADD held 20 cycles");
        vectors++; if (saw_wait !== 1'b0) begin miscompares++; $display("FAIL nomatch_wait: got asserted expected 0"); end
        vectors++; if (saw_ready !== 1'b0) begin miscompares++; $display("FAIL nomatch_ready: got pulse expected none"); end
    endtask

    task automatic test_reset_mid_div();
        bit saw_ready;
        saw_ready = 1'b0;
        @(negedge clk);
        pcpi_valid = 1'b1; pcpi_insn = mk(F7_MULDIV, F3_DIV); pcpi_rs1 = 32'hFFFF_FFF9; pcpi_rs2 = 32'd2;
        #1;
        repeat (10) begin @(negedge clk); #1; end
        reset = 1'b1;
        #1;
        vectors++; if (pcpi_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready: got %b expected 0", pcpi_ready); end
        vectors++; if (pcpi_wr !== 1'b0) begin miscompares++; $display("FAIL rstmid_wr: got %b expected 0", pcpi_wr); end
        vectors++; if (pcpi_wait !== 1'b0) begin miscompares++; $display("FAIL rstmid_wait: got %b expected 0", pcpi_wait); end
        vectors++; if (pcpi_rd !== 32'd0) begin miscompares++; $display("FAIL rstmid_rd: got %h expected 00000000", pcpi_rd); end
        pcpi_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        for (int c = 0; c < 50; c++) begin
            if (pcpi_ready !== 1'b0 || pcpi_wr !== 1'b0) saw_ready = 1'b1;
            @(negedge clk); #1;
        end
        $display("rstmid: reset at cycle 10 of divide");
        vectors++; if (saw_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_ready: got pulse expected none"); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_back_to_back();
        test_abort();
        test_nomatch();
        test_reset_mid_div();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
